// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit <-> datapath signal bundle
//
// Groups the instruction/flag inputs and the control outputs shared between
// the multicycle control unit and the RV64 datapath.
//   master : control unit side (consumes Instruction/ZeroFlag, drives controls)
//   slave  : datapath side (drives Instruction/ZeroFlag, consumes controls)
//   Instruction  32     fetched instruction word
//   ZeroFlag     1      ALU zero flag
//   ALUControl   2      00 add, 01 sub, 10 and, 11 or
//   ALUScr       1      1 selects Imm as ALU SrcB
//   RegWrite     1      register-file write strobe
//   MemWrite     1      data-memory write strobe
//   MemToReg     1      1 selects memory read data for writeback
//   Branch       1      branch qualifier into the PC mux
//   PCWrite      1      PC register write enable
//   Imm          BITS   sign-extended immediate
//   Illegal      1      sticky unsupported-instruction flag
//   InstRet      CNT_W  retired-instruction count

interface multicycle_control_unit_if #(
    parameter int BITS  = 64,
    parameter int CNT_W = 32
);
    logic [31:0]      Instruction;
    logic             ZeroFlag;
    logic [1:0]       ALUControl;
    logic             ALUScr;
    logic             RegWrite;
    logic             MemWrite;
    logic             MemToReg;
    logic             Branch;
    logic             PCWrite;
    logic [BITS-1:0]  Imm;
    logic             Illegal;
    logic [CNT_W-1:0] InstRet;

    modport master (
        input  Instruction, ZeroFlag,
        output ALUControl, ALUScr, RegWrite, MemWrite, MemToReg,
               Branch, PCWrite, Imm, Illegal, InstRet
    );

    modport slave (
        output Instruction, ZeroFlag,
        input  ALUControl, ALUScr, RegWrite, MemWrite, MemToReg,
               Branch, PCWrite, Imm, Illegal, InstRet
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle FSM control unit for an RV64 subset
//
// Sequences add/sub/and/or/addi/ld/sd/beq through FETCH, DECODE, EXEC, MEM
// and WB so that each write strobe and PCWrite is high for a single cycle per
// instruction. Unsupported encodings park the FSM in HALT until rst.
//   clk  in  1   single clock, rising edge
//   rst  in  1   synchronous, active-high reset
//   bus  master modport of multicycle_control_unit_if (see interface header)
// All outputs are Moore: decoded from the state and the latched instruction.

module multicycle_control_unit #(
    parameter int BITS  = 64,
    parameter int CNT_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    multicycle_control_unit_if.master       bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R    = 3'd0,
        C_ADDI = 3'd1,
        C_LD   = 3'd2,
        C_SD   = 3'd3,
        C_BEQ  = 3'd4,
        C_BAD  = 3'd5
    } iclass_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t state_q, state_d;

    // Latched instruction fields. rs1 (bits 19:15) is a datapath concern
    // and is not needed for control, so it is not kept here.
    logic [6:0]  opcode_q;   // IR[6:0]
    logic [4:0]  lo_q;       // IR[11:7]  (rd / imm low bits)
    logic [2:0]  funct3_q;   // IR[14:12]
    logic [11:0] hi_q;       // IR[31:20] (funct7 + rs2 / I-imm)

    logic [CNT_W-1:0] instret_q;

    iclass_t     iclass;
    logic [6:0]  funct7;

    logic [1:0]      alu_control;
    logic            alu_scr;
    logic            reg_write;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
    logic            pc_write;
    logic [BITS-1:0] imm;
    logic            illegal;

    assign funct7 = hi_q[11:5];

    // Instruction classification from the latched fields; any funct mismatch
    // is treated as unsupported.
    always_comb begin
        iclass = C_BAD;
        case (opcode_q)
            OP_R: begin
                if ((funct3_q == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) ||
                    funct3_q == 3'b111 || funct3_q == 3'b110)
                    iclass = C_R;
            end
            OP_ADDI: if (funct3_q == 3'b000) iclass = C_ADDI;
            OP_LD:   if (funct3_q == 3'b011) iclass = C_LD;
            OP_SD:   if (funct3_q == 3'b011) iclass = C_SD;
            OP_BEQ:  if (funct3_q == 3'b000) iclass = C_BEQ;
            default: iclass = C_BAD;
        endcase
    end

    // State register, instruction latch and retired counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            lo_q      <= '0;
            funct3_q  <= '0;
            hi_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                opcode_q <= bus.Instruction[6:0];
                lo_q     <= bus.Instruction[11:7];
                funct3_q <= bus.Instruction[14:12];
                hi_q     <= bus.Instruction[31:20];
            end
            if (pc_write)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (iclass == C_BAD) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (iclass)
                    C_R, C_ADDI: state_d = S_WB;
                    C_LD, C_SD:  state_d = S_MEM;
                    C_BEQ:       state_d = S_FETCH;
                    default:     state_d = S_HALT;
                endcase
            end
            S_MEM:    state_d = (iclass == C_LD) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode.
    always_comb begin
        alu_control = 2'b00;
        alu_scr     = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        branch      = 1'b0;
        pc_write    = 1'b0;
        imm         = '0;
        illegal     = 1'b0;

        if (state_q == S_HALT) begin
            illegal = 1'b1;
        end else if (state_q != S_FETCH) begin
            case (iclass)
                C_R: begin
                    if (funct3_q == 3'b111)      alu_control = 2'b10;
                    else if (funct3_q == 3'b110) alu_control = 2'b11;
                    else if (funct7 == 7'b0100000) alu_control = 2'b01;
                    else                         alu_control = 2'b00;
                end
                C_ADDI, C_LD: imm = {{(BITS-12){hi_q[11]}}, hi_q};
                C_SD:         imm = {{(BITS-12){hi_q[11]}}, hi_q[11:5], lo_q};
                C_BEQ: begin
                    alu_control = 2'b01;
                    // Halfword offset; the datapath applies the final <<1.
                    imm = {{(BITS-12){hi_q[11]}}, hi_q[11], lo_q[0], hi_q[10:5], lo_q[4:1]};
                end
                default: imm = '0;
            endcase

            if ((iclass == C_ADDI || iclass == C_LD || iclass == C_SD) &&
                (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
                alu_scr = 1'b1;

            case (state_q)
                S_EXEC: begin
                    if (iclass == C_BEQ) begin
                        branch   = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_MEM: begin
                    if (iclass == C_SD) begin
                        mem_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    mem_to_reg = (iclass == C_LD);
                end
                default: ;
            endcase
        end
    end

    assign bus.ALUControl = alu_control;
    assign bus.ALUScr     = alu_scr;
    assign bus.RegWrite   = reg_write;
    assign bus.MemWrite   = mem_write;
    assign bus.MemToReg   = mem_to_reg;
    assign bus.Branch     = branch;
    assign bus.PCWrite    = pc_write;
    assign bus.Imm        = imm;
    assign bus.Illegal    = illegal;
    assign bus.InstRet    = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit

module tb_multicycle_control_unit;

    localparam int BITS  = 64;
    localparam int CNT_W = 32;

    localparam int K_R    = 0;
    localparam int K_ADDI = 1;
    localparam int K_LD   = 2;
    localparam int K_SD   = 3;
    localparam int K_BEQ  = 4;
    localparam int K_BAD  = 5;

    logic clk;
    logic rst;

    multicycle_control_unit_if #(.BITS(BITS), .CNT_W(CNT_W)) bus ();

    multicycle_control_unit #(.BITS(BITS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [CNT_W-1:0] retired = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int classify(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (op == 7'h33 && ((f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) || f3 == 3'd7 || f3 == 3'd6))
            return K_R;
        if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
        if (op == 7'h03 && f3 == 3'd3) return K_LD;
        if (op == 7'h23 && f3 == 3'd3) return K_SD;
        if (op == 7'h63 && f3 == 3'd0) return K_BEQ;
        return K_BAD;
    endfunction

    function automatic int latency(input int k);
        case (k)
            K_LD:    return 5;
            K_BEQ:   return 3;
            default: return 4;
        endcase
    endfunction

    function automatic longint exp_imm(input logic [31:0] w, input int k);
        logic signed [11:0] v;
        case (k)
            K_ADDI, K_LD: v = w[31:20];
            K_SD:         v = {w[31:25], w[11:7]};
            K_BEQ:        v = {w[31], w[7], w[30:25], w[11:8]};
            default:      v = 12'sd0;
        endcase
        return longint'(v);
    endfunction

    function automatic logic [1:0] exp_alu(input logic [31:0] w, input int k);
        if (k == K_BEQ) return 2'b01;
        if (k != K_R) return 2'b00;
        if (w[14:12] == 3'd7) return 2'b10;
        if (w[14:12] == 3'd6) return 2'b11;
        return (w[31:25] == 7'h20) ? 2'b01 : 2'b00;
    endfunction

    // {RegWrite, MemWrite, MemToReg, Branch, PCWrite, ALUScr, Illegal}
    function automatic logic [6:0] observed();
        return {bus.RegWrite, bus.MemWrite, bus.MemToReg, bus.Branch,
                bus.PCWrite, bus.ALUScr, bus.Illegal};
    endfunction

    // Expected control strobes for cycle c (1 = fetch) of an instruction.
    function automatic logic [6:0] expected(input int k, input int c);
        int  n;
        logic last, imm_src;
        if (k == K_BAD) return (c >= 3) ? 7'b0000001 : 7'b0000000;
        n       = latency(k);
        last    = (c == n);
        imm_src = (k == K_ADDI || k == K_LD || k == K_SD) && c >= 3;
        return {last && (k == K_R || k == K_ADDI || k == K_LD),
                last && k == K_SD,
                last && k == K_LD,
                last && k == K_BEQ,
                last,
                imm_src,
                1'b0};
    endfunction

    // Entered and left at a negedge inside a FETCH cycle.
    task automatic run_instr(input logic [31:0] w, input int halt_cycles, input logic zf);
        int k, n;
        k = classify(w);
        n = (k == K_BAD) ? 2 + halt_cycles : latency(k);
        for (int c = 1; c <= n; c++) begin
            if (c == 1) check("instret", 64'(bus.InstRet), 64'(retired));
            check($sformatf("w%08h c%0d strobes", w, c), 64'(observed()), 64'(expected(k, c)));
            if (c == 1 || (k != K_BAD && c >= 2) || (k == K_BAD && c >= 3))
                check($sformatf("w%08h c%0d imm", w, c), bus.Imm,
                      (c == 1 || k == K_BAD) ? 64'd0 : 64'(exp_imm(w, k)));
            if (c == 3 && k != K_BAD)
                check($sformatf("w%08h aluctl", w), 64'(bus.ALUControl), 64'(exp_alu(w, k)));
            bus.Instruction = (c == 1) ? w : $urandom;
            bus.ZeroFlag    = (zf === 1'bx) ? 1'($urandom) : zf;
            @(negedge clk);
        end
        if (k != K_BAD) retired++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        retired = '0;
        check("rst strobes", 64'(observed()), 64'd0);
        check("rst instret", 64'(bus.InstRet), 64'd0);
        check("rst imm", bus.Imm, 64'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        logic [2:0] rf3 [4] = '{3'd0, 3'd0, 3'd7, 3'd6};
        logic [6:0] rf7 [4] = '{7'h00, 7'h20, 7'h00, 7'h00};
        w   = $urandom;
        sel = $urandom_range(0, 11);
        case (sel)
            0, 1: begin
                int j = $urandom_range(0, 3);
                w[6:0] = 7'h33; w[14:12] = rf3[j]; w[31:25] = rf7[j];
            end
            2, 3: begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
            4, 5: begin w[6:0] = 7'h03; w[14:12] = 3'd3; end
            6, 7: begin w[6:0] = 7'h23; w[14:12] = 3'd3; end
            8, 9: begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
            10:   begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h01; end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        clk = 1'b0;
        rst = 1'b1;
        bus.Instruction = '0;
        bus.ZeroFlag    = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Directed cases.
        run_instr(32'h00500093, 0, 1'bx);   // addi x1,x0,5
        run_instr(32'h402081B3, 0, 1'bx);   // sub x3,x1,x2
        run_instr(32'hFF80B103, 0, 1'bx);   // ld x2,-8(x1)
        run_instr(32'h0020B823, 0, 1'bx);   // sd x2,16(x1)
        run_instr(32'hFE000EE3, 0, 1'b0);   // beq, not taken
        run_instr(32'hFE000EE3, 0, 1'b1);   // beq, taken
        check("retired after directed", 64'(bus.InstRet), 64'd6);

        // Unsupported word halts for 20 cycles, then reset recovers.
        run_instr(32'h00000000, 20, 1'bx);
        do_reset();

        // Reset on the edge that would enter WB abandons the addi.
        run_instr(32'h00500093, 0, 1'bx);
        bus.Instruction = 32'h00500093;
        @(negedge clk);                     // DECODE
        @(negedge clk);                     // EXEC
        rst = 1'b1;
        @(negedge clk);                     // FETCH after reset
        rst = 1'b0;
        retired = '0;
        check("abandon strobes", 64'(observed()), 64'd0);
        check("abandon instret", 64'(bus.InstRet), 64'd0);
        check("abandon illegal", 64'(bus.Illegal), 64'd0);
        run_instr(32'h00500093, 0, 1'bx);

        // Randomized instruction stream against the reference model.
        for (int i = 0; i < 300; i++) begin
            w = rand_instr();
            if (classify(w) == K_BAD) begin
                run_instr(w, 4, 1'bx);
                do_reset();
            end else begin
                run_instr(w, 0, 1'bx);
            end
        end
        check("final instret", 64'(bus.InstRet), 64'(retired));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
